mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multicycle control unit for the MIPS datapath. Sequences fetch/decode/execute/memory/writeback by driving the datapath mux selects and write enables from a Moore FSM. Waits on a memory-ready handshake and halts on memory timeout. Exposes a retired-instruction counter and the state code for debug and bench checking.

Parameters:
TIMEOUT_CYCLES, 16, consecutive mem_ready=0 cycles in a memory wait state before HALT (must be ≥1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  6  instr[31:26] from instruction register
mem_ready  input  1  memory completes current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
mem_to_reg  output  1  writeback select: 1=MDR, 0=ALUOut
reg_dst  output  1  dest register: 1=rd, 0=rt
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct decode
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
illegal_op  output  1  unsupported opcode seen in DECODE
bus_error  output  1  sticky memory timeout flag
retired  output  CNT_W  completed-instruction count
state_o  output  4  current state code

Behaviour:
- State codes: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, ALU_WB 8, BRANCH 9, JUMP 10, ADDI_EXEC 11, ADDI_WB 12, HALT 15. Codes 13–14 unused and go to IDLE.
- Reset low (asynchronous): state=IDLE, retired=0, bus_error=0, timeout counter=0. All outputs default to 0 unless listed for a state below.
- IDLE: go to FETCH next cycle.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=1 and pc_write=1 only in the cycle mem_ready=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 → EXECUTE
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDI_EXEC
  - any other opcode → FETCH, with illegal_op=1 for this DECODE cycle only; not counted in retired.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_READ for lw, MEM_WRITE for sw (opcode held stable by the IR).
- MEM_READ: mem_read=1, i_or_d=1. On mem_ready=1 go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. On mem_ready=1 go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10, then ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then FETCH.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00, then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- Zero-wait latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Timeout: counter is active in FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle with mem_ready=0.
  - Clears on mem_ready=1 or on leaving the wait state.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0, go to HALT and set bus_error=1.
- HALT: all control outputs 0; only reset exits. bus_error stays 1 until reset.
- retired: increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JUMP or ADDI_WB. Wraps modulo 2^CNT_W.
- Reset mid-instruction: immediate return to IDLE; no reg_write/mem_write pulse after reset assertion.
- Every output is a function of the registered state, plus mem_ready in FETCH only (ir_write/pc_write). No other combinational input-to-output paths.

Test Plan:
- Reset release with mem_ready=1, opcode=100011 → state_o sequence 0,1,2,3,4,5,1; mem_to_reg=reg_write=1 only in state 5; retired=1 after 6 cycles.
- opcode=000000, mem_ready=1 → states 1,2,7,8,1; alu_op=10 in 7; reg_dst=1, reg_write=1 in 8; retired increments.
- sw with mem_ready=0 for 3 cycles in MEM_WRITE → mem_write=1 held for 4 cycles, then FETCH; bus_error=0.
- TIMEOUT_CYCLES=16, mem_ready stuck 0 from reset → FETCH for 16 cycles, then state_o=15, bus_error=1, all strobes 0; reset low → state_o=0, bus_error=0.
- opcode=111111 → illegal_op=1 for exactly the DECODE cycle, next state FETCH, retired unchanged.
- Reset asserted during MEM_READ (state_o=4) → state_o=0 asynchronously, mem_read=0 the same instant, retired=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that steps through fetch, decode,
// execute, memory and writeback. It drives the datapath mux selects and write
// enables, waits on the memory-ready handshake, and halts on a memory timeout.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_o
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXECUTE   = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_ADDI_EXEC = 4'd11;
    localparam logic [3:0] S_ADDI_WB   = 4'd12;
    localparam logic [3:0] S_HALT      = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Timeout counter holds up to TIMEOUT_CYCLES-1; the next stalled cycle halts.
    localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [3:0]    state;
    logic [3:0]    next_state;
    logic [TW-1:0] tcnt;
    logic          wait_state;
    logic          timeout;
    logic          retire;
    logic          op_legal;

    assign wait_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign timeout    = wait_state && !mem_ready && (tcnt == TLAST);
    assign state_o    = state;

    // Next-state selection; a memory timeout overrides any normal transition.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      next_state = S_FETCH;
            S_FETCH:     if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      next_state = S_EXECUTE;
                    OP_LW, OP_SW:  next_state = S_MEM_ADDR;
                    OP_BEQ:        next_state = S_BRANCH;
                    OP_J:          next_state = S_JUMP;
                    OP_ADDI:       next_state = S_ADDI_EXEC;
                    default:       next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WB:    next_state = S_FETCH;
            S_MEM_WRITE: if (mem_ready) next_state = S_FETCH;
            S_EXECUTE:   next_state = S_ALU_WB;
            S_ALU_WB:    next_state = S_FETCH;
            S_BRANCH:    next_state = S_FETCH;
            S_JUMP:      next_state = S_FETCH;
            S_ADDI_EXEC: next_state = S_ADDI_WB;
            S_ADDI_WB:   next_state = S_FETCH;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_IDLE;
        endcase
        if (timeout) next_state = S_HALT;
    end

    // An instruction retires when its final state hands control back to FETCH.
    always_comb begin
        retire = 1'b0;
        if (next_state == S_FETCH) begin
            case (state)
                S_MEM_WB, S_MEM_WRITE, S_ALU_WB,
                S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
                default:                     retire = 1'b0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Stall counter: counts stalled cycles while the FSM stays in a wait state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                           tcnt <= '0;
        else if (wait_state && !mem_ready && next_state == state) tcnt <= tcnt + TW'(1);
        else                                                  tcnt <= '0;
    end

    // Sticky bus error, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       bus_error <= 1'b0;
        else if (timeout) bus_error <= 1'b1;
    end

    // Retired-instruction counter, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      retired <= '0;
        else if (retire) retired <= retired + CNT_W'(1);
    end

    // Opcode legality check used to flag unsupported instructions in DECODE.
    always_comb begin
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    end

    // Moore control outputs; only FETCH looks at mem_ready for the IR/PC load.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = !op_legal;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: builds an expected cycle-by-cycle trace
// from randomly chosen instructions and memory wait times, then replays it.
module tb_mips_multicycle_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        illegal_op, bus_error;
    logic [31:0] retired;
    logic [3:0]  state_o;
    logic [15:0] ctrl_bus;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  st;
        logic        mr;
        logic [5:0]  op;
        logic [31:0] ret;
        logic        ill;
        logic        be;
    } entry_t;

    entry_t      plan[$];
    int unsigned model_ret;

    mips_multicycle_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .bus_error(bus_error),
        .retired(retired), .state_o(state_o)
    );

    assign ctrl_bus = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Expected control word for a state, in the same bit order as ctrl_bus.
    function automatic logic [15:0] expCtrl(input logic [3:0] st, input logic mr);
        logic pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa;
        logic [1:0] sb, aop, psrc;
        {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
        sb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            4'd1:  begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
            4'd2:  sb = 2'b11;
            4'd3:  begin sa = 1; sb = 2'b10; end
            4'd4:  begin mrd = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mwr = 1; iord = 1; end
            4'd7:  begin sa = 1; aop = 2'b10; end
            4'd8:  begin rw = 1; rdst = 1; end
            4'd9:  begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            4'd10: begin pw = 1; psrc = 2'b10; end
            4'd11: begin sa = 1; sb = 2'b10; end
            4'd12: rw = 1;
            default: pw = 0;
        endcase
        return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, psrc};
    endfunction

    // Instruction class: 0 illegal, 1 lw, 2 sw, 3 R-type, 4 beq, 5 j, 6 addi.
    function automatic int classify(input logic [5:0] op);
        case (op)
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000000: return 3;
            6'b000100: return 4;
            6'b000010: return 5;
            6'b001000: return 6;
            default:   return 0;
        endcase
    endfunction

    function automatic logic rndBit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic addCycle(input logic [3:0] st, input logic mr, input logic [5:0] op,
                            input logic ill, input logic be);
        entry_t e;
        e.st = st; e.mr = mr; e.op = op; e.ret = model_ret; e.ill = ill; e.be = be;
        plan.push_back(e);
    endtask

    // A memory wait: 'waits' stalled cycles followed by the completing cycle.
    task automatic addWait(input logic [3:0] st, input logic [5:0] op, input int waits);
        for (int i = 0; i < waits; i++) addCycle(st, 1'b0, op, 1'b0, 1'b0);
        addCycle(st, 1'b1, op, 1'b0, 1'b0);
    endtask

    // Expected trace of one whole instruction, from FETCH to the last state.
    task automatic addInstr(input logic [5:0] op, input int fw, input int mw);
        int kind;
        kind = classify(op);
        addWait(4'd1, op, fw);
        addCycle(4'd2, rndBit(), op, kind == 0, 1'b0);
        case (kind)
            1: begin addCycle(4'd3, rndBit(), op, 0, 0); addWait(4'd4, op, mw); addCycle(4'd5, rndBit(), op, 0, 0); end
            2: begin addCycle(4'd3, rndBit(), op, 0, 0); addWait(4'd6, op, mw); end
            3: begin addCycle(4'd7, rndBit(), op, 0, 0); addCycle(4'd8, rndBit(), op, 0, 0); end
            4: addCycle(4'd9, rndBit(), op, 0, 0);
            5: addCycle(4'd10, rndBit(), op, 0, 0);
            6: begin addCycle(4'd11, rndBit(), op, 0, 0); addCycle(4'd12, rndBit(), op, 0, 0); end
            default: kind = 0;
        endcase
        if (kind != 0) model_ret++;
    endtask

    task automatic checkCycle(input entry_t e);
        checkOutput("state", 32'(state_o), 32'(e.st));
        checkOutput("ctrl", 32'(ctrl_bus), 32'(expCtrl(e.st, e.mr)));
        checkOutput("retired", retired, e.ret);
        checkOutput("illegal_op", 32'(illegal_op), 32'(e.ill));
        checkOutput("bus_error", 32'(bus_error), 32'(e.be));
    endtask

    // Drive one planned cycle's inputs, check mid-cycle, advance past the edge.
    task automatic applyStimulus(input entry_t e);
        mem_ready = e.mr;
        opcode    = e.op;
        @(negedge clk);
        checkCycle(e);
        @(posedge clk);
        #1;
    endtask

    task automatic runPlan();
        entry_t e;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            applyStimulus(e);
        end
    endtask

    function automatic logic [5:0] randomOp();
        logic [5:0] ops [6];
        int pick;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
        pick = $urandom_range(0, 7);
        if (pick < 6)  return ops[pick];
        if (pick == 6) return 6'b111111;
        return 6'($urandom);
    endfunction

    function automatic int randomWait();
        if ($urandom_range(0, 5) == 0) return TIMEOUT - 1;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        entry_t rst_e;
        reset = 1'b0; mem_ready = 1'b0; opcode = 6'b0;
        model_ret = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst_e.st = 4'd0; rst_e.mr = 1'b0; rst_e.op = 6'b0; rst_e.ret = 0; rst_e.ill = 0; rst_e.be = 0;
        checkCycle(rst_e);
        @(posedge clk);
        #1 reset = 1'b1;

        // Directed sequences first, then random instruction mix.
        addCycle(4'd0, 1'b1, 6'b100011, 1'b0, 1'b0);
        addInstr(6'b100011, 0, 0);
        addInstr(6'b000000, 0, 0);
        addInstr(6'b101011, 0, 3);
        addInstr(6'b111111, 0, 0);
        addInstr(6'b000100, 1, 0);
        addInstr(6'b000010, 0, 0);
        addInstr(6'b001000, 2, 0);
        addInstr(6'b100011, TIMEOUT - 1, TIMEOUT - 1);
        for (int i = 0; i < 40; i++) addInstr(randomOp(), randomWait(), randomWait());
        runPlan();

        // Reset asserted in the middle of a MEM_READ stall.
        addWait(4'd1, 6'b100011, 0);
        addCycle(4'd2, 1'b0, 6'b100011, 1'b0, 1'b0);
        addCycle(4'd3, 1'b0, 6'b100011, 1'b0, 1'b0);
        runPlan();
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("memread_state", 32'(state_o), 32'd4);
        checkOutput("memread_strobe", 32'(mem_read), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_reset_state", 32'(state_o), 32'd0);
        checkOutput("async_reset_memread", 32'(mem_read), 32'd0);
        checkOutput("async_reset_retired", retired, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("held_reset_ctrl", 32'(ctrl_bus), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Memory never ready: FETCH stalls out into HALT with bus_error set.
        model_ret = 0;
        addCycle(4'd0, 1'b0, 6'b100011, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) addCycle(4'd1, 1'b0, 6'b100011, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) addCycle(4'd15, rndBit(), 6'b100011, 1'b0, 1'b1);
        runPlan();
        #2 reset = 1'b0;
        #1;
        checkOutput("halt_reset_state", 32'(state_o), 32'd0);
        checkOutput("halt_reset_bus_error", 32'(bus_error), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
